// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-bit shift sequencer.
//   state_t : sequencer FSM states (IDLE, SHIFT, DONE)
//   OP_*    : latched operation encoding, packed as {lr, la}
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operation encoding {lr, la}. For left shifts la is forced to 0 so
    // that SLL has a single representation.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

endpackage

// File: rtl/shifter.sv
// Single-bit shift stage (purely combinational).
//   a  : 8-bit operand
//   lr : 0 = shift left, 1 = shift right
//   la : right shifts only, 1 = arithmetic (replicate a[7]), 0 = logical
//   y  : shifted value
//   c  : bit shifted out (a[7] for left, a[0] for right)
module shifter (
    input  logic [7:0] a,
    input  logic       lr,
    input  logic       la,
    output logic [7:0] y,
    output logic       c
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign y[gi] = lr ? a[gi + 1] : 1'b0;
            end else if (gi == 7) begin : g_msb
                // Right: sign fill only for arithmetic shifts.
                assign y[gi] = lr ? (la & a[7]) : a[gi - 1];
            end else begin : g_mid
                assign y[gi] = lr ? a[gi + 1] : a[gi - 1];
            end
        end
    endgenerate

    assign c = lr ? a[0] : a[7];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller wrapped around the single-bit shifter stage.
// Latches operand, count and shift type on start, iterates the shifter once
// per clock, then publishes the result and flags with a one-cycle done pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   lr, la       : shift type (lr=0 SLL; lr=1 la=1 SRA; lr=1 la=0 SRL)
//   a_in, amt    : operand and number of single-bit shifts
//   busy, done   : busy in SHIFT/DONE; done pulses in DONE
//   y, c_out     : registered result and last bit shifted out
//   z_out, n_out : zero and negative flags of y
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lr,
    input  logic             la,
    input  logic [7:0]       a_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [7:0]       y,
    output logic             c_out,
    output logic             z_out,
    output logic             n_out
);

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       y_q, y_d;
    logic             c_out_q, c_out_d;
    logic             z_out_q, z_out_d;
    logic             n_out_q, n_out_d;

    logic [7:0]       sh_y;
    logic             sh_c;
    logic             sh_lr;
    logic             sh_la;

    assign sh_lr = (op_q == OP_SRA) || (op_q == OP_SRL);
    assign sh_la = (op_q == OP_SRA);

    shifter u_shifter (
        .a  (acc_q),
        .lr (sh_lr),
        .la (sh_la),
        .y  (sh_y),
        .c  (sh_c)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        y_d     = y_q;
        c_out_d = c_out_q;
        z_out_d = z_out_q;
        n_out_d = n_out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = a_in;
                    cnt_d   = amt;
                    carry_d = 1'b0;
                    // Left shifts ignore la; keep one encoding for SLL.
                    op_d    = lr ? {1'b1, la} : OP_SLL;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    y_d     = acc_q;
                    c_out_d = carry_q;
                    z_out_d = (acc_q == 8'h00);
                    n_out_d = acc_q[7];
                    state_d = DONE;
                end else begin
                    acc_d   = sh_y;
                    carry_d = sh_c;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_SLL;
            y_q     <= 8'h00;
            c_out_q <= 1'b0;
            z_out_q <= 1'b0;
            n_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            y_q     <= y_d;
            c_out_q <= c_out_d;
            z_out_q <= z_out_d;
            n_out_q <= n_out_d;
        end
    end

    assign busy  = (state_q == SHIFT) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign y     = y_q;
    assign c_out = c_out_q;
    assign z_out = z_out_q;
    assign n_out = n_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       lr;
    logic       la;
    logic [7:0] a_in;
    logic [2:0] amt;
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       c_out;
    logic       z_out;
    logic       n_out;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(.AMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .lr    (lr),
        .la    (la),
        .a_in  (a_in),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .c_out (c_out),
        .z_out (z_out),
        .n_out (n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic d,
                              input logic [7:0] ye, input logic ce,
                              input logic ze, input logic ne);
        check({tag, ".busy"},  {7'd0, busy},  {7'd0, b});
        check({tag, ".done"},  {7'd0, done},  {7'd0, d});
        check({tag, ".y"},     y,             ye);
        check({tag, ".c_out"}, {7'd0, c_out}, {7'd0, ce});
        check({tag, ".z_out"}, {7'd0, z_out}, {7'd0, ze});
        check({tag, ".n_out"}, {7'd0, n_out}, {7'd0, ne});
        $display("step %s: busy=%b done=%b y=%h c=%b z=%b n=%b", tag, busy, done, y, c_out, z_out, n_out);
    endtask

    // Issue one operation and check the cycle-exact handshake plus result.
    // prev_y is the result of the previous operation, which must hold while busy.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] n,
                          input logic l, input logic ar, input logic [7:0] prev_y,
                          input logic [7:0] ye, input logic ce, input logic ze, input logic ne);
        a_in  = a;
        amt   = n;
        lr    = l;
        la    = ar;
        start = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        a_in  = ~a;                   // latched copies must be used
        amt   = ~n;
        for (int k = 1; k <= int'(n); k++) begin
            check({tag, ".busy_mid"}, {7'd0, busy}, 8'd1);
            check({tag, ".done_mid"}, {7'd0, done}, 8'd0);
            check({tag, ".y_hold"},   y,            prev_y);
            tick();                   // edge k
        end
        check({tag, ".pre_done"}, {7'd0, done}, 8'd0);
        tick();                       // edge n+1
        check_outs(tag, 1'b1, 1'b1, ye, ce, ze, ne);
        tick();
        check({tag, ".idle_busy"}, {7'd0, busy}, 8'd0);
        check({tag, ".idle_done"}, {7'd0, done}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        lr    = 1'b0;
        la    = 1'b0;
        a_in  = 8'hA5;
        amt   = 3'd5;
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check_outs("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        run_op("sll",   8'h81, 3'd1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("sra",   8'h90, 3'd3, 1'b1, 1'b1, 8'h02, 8'hF2, 1'b0, 1'b0, 1'b1);
        run_op("srl",   8'h0D, 3'd4, 1'b1, 1'b0, 8'hF2, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("zero",  8'h55, 3'd0, 1'b0, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
        run_op("sramx", 8'h80, 3'd7, 1'b1, 1'b1, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1);
        // la is ignored for left shifts
        run_op("sllla", 8'hC3, 3'd2, 1'b0, 1'b1, 8'hFF, 8'h0C, 1'b1, 1'b0, 1'b0);

        // start pulse during SHIFT is ignored; done pulses exactly once
        a_in = 8'h90; amt = 3'd3; lr = 1'b1; la = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_in = 8'hFF; amt = 3'd1; lr = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check({"intf", ".busy_mid"}, {7'd0, busy}, 8'd1);
        tick();
        check({"intf", ".pre_done"}, {7'd0, done}, 8'd0);
        tick();
        check_outs("intf", 1'b1, 1'b1, 8'hF2, 1'b0, 1'b0, 1'b1);
        tick();
        check({"intf", ".done_once"}, {7'd0, done}, 8'd0);
        check({"intf", ".idle"},      {7'd0, busy}, 8'd0);

        // asynchronous reset mid-SHIFT
        a_in = 8'h81; amt = 3'd7; lr = 1'b0; la = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check({"rstmid", ".busy_before"}, {7'd0, busy}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rstmid", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        check_outs("rsthold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (8) tick();
        check({"rstrel", ".done"}, {7'd0, done}, 8'd0);
        check({"rstrel", ".busy"}, {7'd0, busy}, 8'd0);

        // operation after reset works from a clean state
        run_op("post",  8'h01, 3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
